// File: rtl/serial_adder_pkg.sv
// Shared state encoding and sizing helpers for the digit-serial adder/subtractor.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nstep(int width, int digit);
        return width / digit;
    endfunction

    // A single-step configuration still needs a one-bit counter.
    function automatic int cnt_width(int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// Single-bit full-adder cell; chained DIGIT times to form one serial digit.
module serial_adder_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: WIDTH-bit operands consumed DIGIT bits per clock,
// LSB digit first, with valid/ready handshakes on both sides.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSTEP = nstep(WIDTH, DIGIT);
    localparam int CW    = cnt_width(NSTEP);
    localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] op_a, op_b, res, res_nx;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [DIGIT:0]   c;
    logic [DIGIT-1:0] d;
    logic             last;

    assign c[0] = carry;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        serial_adder_fa u_fa (
            .a    (op_a[i]),
            .b    (op_b[i]),
            .cin  (c[i]),
            .sum  (d[i]),
            .cout (c[i+1])
        );
    end

    // New digit enters at the MSB end; written this way so DIGIT == WIDTH needs no special case.
    assign res_nx = WIDTH'({d, res} >> DIGIT);
    assign last   = (cnt == LAST);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)  state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction as A + ~B + 1: invert B and seed the carry.
                        op_a  <= a;
                        op_b  <= b ^ {WIDTH{sub}};
                        carry <= sub;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    op_a  <= op_a >> DIGIT;
                    op_b  <= op_b >> DIGIT;
                    res   <= res_nx;
                    carry <= c[DIGIT];
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        sum  <= res_nx;
                        cout <= c[DIGIT];
                        ovf  <= c[DIGIT] ^ c[DIGIT-1];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: an 8-bit/1-digit and a 16-bit/4-digit instance
// checked against an integer-arithmetic reference model.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        iv8, ir8, ov8, or8, sb8, co8, vf8;
    logic [7:0]  a8, b8, s8;
    logic        iv16, ir16, ov16, or16, sb16, co16, vf16;
    logic [15:0] a16, b16, s16;

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .sub(sb8), .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .ovf(vf8)
    );

    serial_adder #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .sub(sb16), .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16), .ovf(vf16)
    );

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
        int          acc;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic ovq[2] = '{1'b0, 1'b0};
    bit   rnd_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rnd_rdy) begin
            #1;
            or8  = 1'($urandom_range(0, 1));
            or16 = 1'($urandom_range(0, 1));
        end
    end

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, expv, cyc);
        end
    endfunction

    function automatic void fail(string nm);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endfunction

    function automatic exp_t mk(logic [15:0] s, logic c, logic o);
        exp_t e;
        e.s = s; e.c = c; e.o = o; e.acc = 0;
        return e;
    endfunction

    // Plain integer arithmetic: unsigned result/carry and signed range check.
    function automatic exp_t model(int w, logic [15:0] av, logic [15:0] bv, logic sv);
        exp_t   e;
        longint m  = longint'(1) << w;
        longint ua = longint'(av) % m;
        longint ub = longint'(bv) % m;
        longint sa = (ua >= m / 2) ? ua - m : ua;
        longint sb = (ub >= m / 2) ? ub - m : ub;
        longint r, rs;
        if (sv) begin
            r   = ua - ub;
            e.c = (ua >= ub);
            rs  = sa - sb;
        end else begin
            r   = ua + ub;
            e.c = (r >= m);
            rs  = sa + sb;
        end
        e.s   = 16'((r + m) % m);
        e.o   = (rs < -(m / 2)) || (rs >= m / 2);
        e.acc = 0;
        return e;
    endfunction

    function automatic logic rdy(int u);
        return (u == 0) ? ir8 : ir16;
    endfunction

    function automatic int qsize(int u);
        return (u == 0) ? q8.size() : q16.size();
    endfunction

    function automatic void mon(int u);
        logic        ov, rd, c, o;
        logic [15:0] s;
        int          ns;
        exp_t        e;
        if (u == 0) begin
            ov = ov8; rd = or8; s = {8'h00, s8}; c = co8; o = vf8; ns = 8;
        end else begin
            ov = ov16; rd = or16; s = s16; c = co16; o = vf16; ns = 4;
        end
        if (!rst_n) begin
            ovq[u] = 1'b0;
            return;
        end
        if (ov && !ovq[u]) begin
            if (qsize(u) == 0) fail($sformatf("unexpected_out_valid_u%0d", u));
            else begin
                e = (u == 0) ? q8[0] : q16[0];
                chk($sformatf("latency_u%0d", u), cyc - e.acc, ns);
            end
        end
        if (ov && rd && qsize(u) > 0) begin
            e = (u == 0) ? q8.pop_front() : q16.pop_front();
            chk($sformatf("sum_u%0d", u), s, e.s);
            chk($sformatf("cout_u%0d", u), c, e.c);
            chk($sformatf("ovf_u%0d", u), o, e.o);
        end
        ovq[u] = ov;
    endfunction

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic issue(int u, logic [15:0] av, logic [15:0] bv, logic sv, exp_t e);
        int n = 0;
        @(posedge clk); #1;
        if (u == 0) begin iv8 = 1'b1; a8 = av[7:0]; b8 = bv[7:0]; sb8 = sv; end
        else begin iv16 = 1'b1; a16 = av; b16 = bv; sb16 = sv; end
        @(negedge clk);
        while (!rdy(u) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rdy(u)) begin
            fail($sformatf("accept_timeout_u%0d", u));
            if (u == 0) iv8 = 1'b0; else iv16 = 1'b0;
            return;
        end
        @(posedge clk); #1;
        e.acc = cyc;
        // Scramble operands right after acceptance; the result must not follow them.
        if (u == 0) begin
            q8.push_back(e);
            iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sb8 = 1'($urandom);
        end else begin
            q16.push_back(e);
            iv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); sb16 = 1'($urandom);
        end
    endtask

    task automatic drain(int u);
        int n = 0;
        while (qsize(u) != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (qsize(u) != 0) fail($sformatf("drain_timeout_u%0d", u));
    endtask

    logic [15:0] ra8, rb8, ra16, rb16;
    logic        rs8, rs16;
    int          n_w;
    bit          seen;

    initial begin
        or8 = 1'b1; or16 = 1'b1;
        iv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); sb8 = 1'($urandom);
        iv16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom); sb16 = 1'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready8", ir8, 1);   chk("rst_out_valid8", ov8, 0);
        chk("rst_sum8", s8, 0);         chk("rst_cout8", co8, 0);     chk("rst_ovf8", vf8, 0);
        chk("rst_in_ready16", ir16, 1); chk("rst_out_valid16", ov16, 0);
        chk("rst_sum16", s16, 0);       chk("rst_cout16", co16, 0);   chk("rst_ovf16", vf16, 0);
        iv8 = 1'b0; iv16 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        issue(0, 16'h5A, 16'h3C, 1'b0, mk(16'h96, 1'b0, 1'b1));
        issue(0, 16'hFF, 16'h01, 1'b0, mk(16'h00, 1'b1, 1'b0));
        issue(0, 16'h10, 16'h20, 1'b1, mk(16'hF0, 1'b0, 1'b0));
        issue(0, 16'h80, 16'h01, 1'b1, mk(16'h7F, 1'b1, 1'b1));
        drain(0);

        // Backpressure: hold the result in DONE while in_valid and operands churn.
        @(posedge clk); #1;
        or8 = 1'b0;
        issue(0, 16'h33, 16'h44, 1'b0, mk(16'h77, 1'b0, 1'b0));
        n_w = 0;
        @(negedge clk);
        while (!ov8 && n_w < 50) begin
            @(negedge clk);
            n_w++;
        end
        if (!ov8) fail("bp_out_valid_timeout");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            iv8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); sb8 = 1'($urandom);
            @(negedge clk);
            chk("bp_sum", s8, 8'h77);   chk("bp_cout", co8, 0);  chk("bp_ovf", vf8, 0);
            chk("bp_in_ready", ir8, 0); chk("bp_out_valid", ov8, 1);
        end
        @(posedge clk); #1;
        iv8 = 1'b0; or8 = 1'b1;
        issue(0, 16'hC8, 16'h64, 1'b1, model(8, 16'hC8, 16'h64, 1'b1));
        drain(0);

        // Abort mid-RUN: no result may appear for the aborted operation.
        issue(0, 16'h12, 16'h34, 1'b0, model(8, 16'h12, 16'h34, 1'b0));
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        q8.delete();
        q16.delete();
        @(negedge clk);
        chk("abort_in_ready", ir8, 1); chk("abort_out_valid", ov8, 0);
        chk("abort_sum", s8, 0);       chk("abort_cout", co8, 0);  chk("abort_ovf", vf8, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (ov8) seen = 1'b1;
        end
        chk("abort_no_out_valid", seen, 0);
        issue(0, 16'h01, 16'h01, 1'b0, mk(16'h02, 1'b0, 1'b0));
        drain(0);

        // Random traffic on both configurations with random consumer stalls.
        @(posedge clk); #2;
        rnd_rdy = 1'b1;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    ra8 = 16'($urandom_range(0, 255));
                    rb8 = 16'($urandom_range(0, 255));
                    rs8 = 1'($urandom_range(0, 1));
                    issue(0, ra8, rb8, rs8, model(8, ra8, rb8, rs8));
                end
            end
            begin
                for (int i = 0; i < 30; i++) begin
                    ra16 = 16'($urandom);
                    rb16 = 16'($urandom);
                    rs16 = 1'($urandom_range(0, 1));
                    issue(1, ra16, rb16, rs16, model(16, ra16, rb16, rs16));
                end
            end
        join
        @(posedge clk); #2;
        rnd_rdy = 1'b0;
        or8 = 1'b1; or16 = 1'b1;
        drain(0);
        drain(1);
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised digit-serial adder/subtractor. It generalises the single-bit full-adder cell into a WIDTH-bit datapath that processes DIGIT bits per clock, using DIGIT chained full-adder cells and a registered carry. Operands enter and results leave through valid/ready handshakes. It serves as the area-optimised arithmetic unit for multi-cycle datapaths that cannot afford a full-width ripple or carry-lookahead adder.

## Interface
- WIDTH, 8: operand/result width in bits; must be ≥ 2 and a multiple of DIGIT.
- DIGIT, 1: bits processed per clock (number of chained full-adder cells).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept operands (IDLE only).
- a  input  WIDTH  operand A; sampled on input handshake only.
- b  input  WIDTH  operand B; sampled on input handshake only.
- sub  input  1  0: compute A+B; 1: compute A−B. Sampled on input handshake.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  final carry out. For sub=1: 1 = no borrow (A ≥ B unsigned).
- ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- NSTEP = WIDTH/DIGIT.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch A into op_a and (B XOR {WIDTH{sub}}) into op_b; set carry=sub; clear step counter; go to RUN.
- RUN:
  - Each cycle, the DIGIT-bit FA chain adds op_a[DIGIT-1:0], op_b[DIGIT-1:0] and carry.
  - op_a and op_b shift right by DIGIT.
  - The digit result shifts into the result register from the MSB side.
  - carry takes the chain carry-out.
  - On the final step (count == NSTEP−1): also capture the carry into the MSB (the carry into the top FA cell), then go to DONE.
- DONE:
  - out_valid=1.
  - sum, cout and ovf are held stable until out_valid && out_ready; then go to IDLE.
- in_valid outside IDLE is ignored. Changes to a, b or sub after acceptance do not affect the result.
- Reset (any state, including mid-RUN): abort immediately to IDLE. No out_valid for the aborted operation.
- Arithmetic: all unsigned modulo 2^WIDTH. ovf is meaningful for signed interpretation in both add and subtract modes.

## Timing
- Reset values: in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, state IDLE, counter 0.
- Latency: input handshake at edge E0 → out_valid=1 after edge E0+NSTEP.
- If out_ready=1 when out_valid rises, the output handshake occurs at edge E0+NSTEP+1, and in_ready=1 from then on.
- Throughput: one operation per NSTEP+2 cycles maximum.
- in_ready and out_valid are decoded from registered state only, with no combinational input-to-output paths.
- sum, cout and ovf are registered; they change only on the final RUN edge and on reset.
- Outputs retain the last result after returning to IDLE.

## Structure
- Shared header adder_defs.vh holds:
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the NSTEP derivation macro.
- Sub-module: the team's existing single-bit full-adder cell FA (ports A, B, Cin, Sum, Cout), generated DIGIT times in a ripple chain.
- No other sub-modules. Counter width is $clog2(NSTEP) with a minimum of 1.

## Test plan
- **Reset:** assert rst_n=0 with random inputs → in_ready=1, out_valid=0, sum=0, cout=0, ovf=0.
- **Add, WIDTH=8, DIGIT=1:** a=8'h5A, b=8'h3C, sub=0 → sum=8'h96, cout=0, ovf=1; out_valid rises exactly 8 cycles after acceptance.
- **Add wrap-around:** a=8'hFF, b=8'h01 → sum=8'h00, cout=1, ovf=0.
- **Subtract:**
  - a=8'h10, b=8'h20, sub=1 → sum=8'hF0, cout=0, ovf=0.
  - a=8'h80, b=8'h01, sub=1 → sum=8'h7F, cout=1, ovf=1.
- **Backpressure:** hold out_ready=0 for 5 cycles in DONE while toggling in_valid, a and b → sum/cout/ovf stable, in_ready=0, no new operation accepted. Release → back-to-back next operation correct.
- **Reset mid-RUN and wide/multi-digit config:**
  - Pulse rst_n low at step 3 → IDLE and no out_valid; the following op 8'h01+8'h01 → sum=8'h02.
  - Repeat random add/sub against a reference model with WIDTH=16, DIGIT=4 → latency 4 cycles, all results match.
